// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte intake, shifter plus one holding register,
// back-to-back frames with no idle gap, registered glitch-free tx.
module uart_tx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       busy
);

   localparam int            CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]    r_bit, w_bit_nxt;
   logic [7:0]    r_shift, w_shift_nxt;
   logic [7:0]    r_hold, w_hold_nxt;
   logic          r_hold_full, w_hold_full_nxt;
   logic          r_tx, w_tx_nxt;
   logic          w_tc, w_acc, w_free;

   assign w_tc   = (r_cnt == TC);
   assign w_acc  = valid && !r_hold_full;
   // Shifter can take a new byte this edge: idle, or finishing the stop bit.
   assign w_free = (r_state == IDLE) || ((r_state == STOP) && w_tc);

   assign ready = !r_hold_full;
   assign tx    = r_tx;
   assign busy  = (r_state != IDLE) || r_hold_full;

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = (r_state == IDLE || w_tc) ? '0 : r_cnt + CW'(1);
      w_bit_nxt       = r_bit;
      w_shift_nxt     = r_shift;
      w_hold_nxt      = r_hold;
      w_hold_full_nxt = r_hold_full;
      case (r_state)
         IDLE: begin
            if (w_acc) begin
               w_state_nxt = START;
               w_shift_nxt = data_in;
            end
         end
         START: begin
            if (w_tc) begin
               w_state_nxt = DATA;
               w_bit_nxt   = 3'd0;
            end
         end
         DATA: begin
            if (w_tc) begin
               w_shift_nxt = {1'b0, r_shift[7:1]};
               w_bit_nxt   = r_bit + 3'd1;
               if (r_bit == 3'd7) w_state_nxt = STOP;
            end
         end
         STOP: begin
            if (w_tc) begin
               if (r_hold_full) begin
                  w_state_nxt     = START;
                  w_shift_nxt     = r_hold;
                  w_hold_full_nxt = 1'b0;
               end else if (w_acc) begin
                  w_state_nxt = START;
                  w_shift_nxt = data_in;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_acc && !w_free) begin
         w_hold_nxt      = data_in;
         w_hold_full_nxt = 1'b1;
      end
      // tx follows the next state so the line moves on the same edge as the bit boundary.
      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = w_shift_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_bit       <= 3'd0;
         r_shift     <= 8'h00;
         r_hold      <= 8'h00;
         r_hold_full <= 1'b0;
         r_tx        <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_bit       <= w_bit_nxt;
         r_shift     <= w_shift_nxt;
         r_hold      <= w_hold_nxt;
         r_hold_full <= w_hold_full_nxt;
         r_tx        <= w_tx_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (CLKS_PER_BIT 4 and 2) checked every cycle against a
// line-level model (queue of expected tx samples) plus a UART receiver model on the fast one.
module tb_uart_tx;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] rst, valid;
   logic [7:0] din [2];
   wire  [1:0] ready, tx, busy;

   uart_tx #(.CLKS_PER_BIT(4)) u_dut0 (
      .clk(clk), .rst(rst[0]), .data_in(din[0]), .valid(valid[0]),
      .ready(ready[0]), .tx(tx[0]), .busy(busy[0]));
   uart_tx #(.CLKS_PER_BIT(2)) u_dut1 (
      .clk(clk), .rst(rst[1]), .data_in(din[1]), .valid(valid[1]),
      .ready(ready[1]), .tx(tx[1]), .busy(busy[1]));

   int         cpb [2] = '{4, 2};
   int         n_tests = 0, n_fail = 0, cyc = 0;
   bit         lq  [2][$];      // expected tx value for each upcoming cycle
   logic [7:0] src [2][$];      // bytes the bench wants to send
   bit         rnd_en = 1'b0;
   int         acc_cyc[$];
   logic [7:0] sent1[$], rxq[$];
   bit         rx_act = 1'b0;
   int         rx_t = 0;
   logic [7:0] rx_b = 8'h00;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      bit acc [2];
      for (int i = 0; i < 2; i++) begin
         bit en;
         en       = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
         valid[i] = (src[i].size() > 0) && en && !rst[i];
         din[i]   = valid[i] ? src[i][0] : 8'($urandom);
         acc[i]   = valid[i] && (lq[i].size() < 10 * cpb[i]);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         bit         et, eb, er;
         logic [7:0] b;
         if (rst[i]) lq[i].delete();
         else if (acc[i]) begin
            b = src[i].pop_front();
            if (i == 0) acc_cyc.push_back(cyc);
            else sent1.push_back(b);
            for (int j = 0; j < 10; j++)
               for (int k = 0; k < cpb[i]; k++)
                  lq[i].push_back((j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1]);
         end
         eb = lq[i].size() > 0;
         et = eb ? lq[i].pop_front() : 1'b1;
         er = lq[i].size() < 10 * cpb[i];
         chk($sformatf("tx%0d", i), tx[i], et);
         chk($sformatf("ready%0d", i), ready[i], er);
         chk($sformatf("busy%0d", i), busy[i], eb);
      end
      // Receiver on the CLKS_PER_BIT=2 line, sampling mid-bit.
      if (!rx_act) begin
         if (tx[1] == 1'b0) begin
            rx_act = 1'b1;
            rx_t   = 0;
         end
      end else begin
         rx_t++;
         for (int k = 1; k <= 8; k++)
            if (rx_t == 2 * k + 1) rx_b[k-1] = tx[1];
         if (rx_t == 19) begin
            chk("rx_stop", tx[1], 1'b1);
            rxq.push_back(rx_b);
            rx_act = 1'b0;
         end
      end
   endtask

   initial begin
      int nb;
      rst   = 2'b11;
      valid = 2'b00;
      din[0] = 8'h00;
      din[1] = 8'h00;
      step();
      step();
      rst = 2'b00;

      repeat (100) step();

      // Single byte
      src[0].push_back(8'hA5);
      nb = 0;
      repeat (45) begin
         step();
         nb += int'(busy[0]);
      end
      chk("a5_busy_len", nb, 40);

      // Two bytes with valid held high
      acc_cyc.delete();
      src[0].push_back(8'h00);
      src[0].push_back(8'hFF);
      nb = 0;
      for (int g = 0; g < 200 && (nb == 0 || busy[0]); g++) begin
         step();
         nb += int'(busy[0]);
      end
      chk("b2b_len", nb, 80);
      chk("b2b_accepts", acc_cyc.size(), 2);
      if (acc_cyc.size() == 2) chk("b2b_acc_gap", acc_cyc[1] - acc_cyc[0], 1);

      // Byte presented during the last stop cycle
      repeat (5) step();
      src[0].push_back(8'h3C);
      step();
      for (int g = 0; g < 100 && lq[0].size() != 0; g++) step();
      chk("last_stop_reached", lq[0].size(), 0);
      chk("last_stop_busy", busy[0], 1'b1);
      src[0].push_back(8'hC3);
      step();
      chk("nogap_start", tx[0], 1'b0);
      for (int g = 0; g < 100 && busy[0]; g++) step();
      chk("nogap_idle", busy[0], 1'b0);

      // Reset during data bit 3 with a byte held
      repeat (3) step();
      src[0].push_back(8'h5A);
      src[0].push_back(8'h96);
      repeat (18) step();
      chk("held_before_rst", ready[0], 1'b0);
      rst[0] = 1'b1;
      step();
      rst[0] = 1'b0;
      chk("rst_tx", tx[0], 1'b1);
      chk("rst_ready", ready[0], 1'b1);
      nb = 0;
      repeat (60) begin
         step();
         nb += int'(busy[0]);
      end
      chk("rst_no_frame", nb, 0);

      // Random streams with random valid gaps on both instances
      rnd_en = 1'b1;
      for (int n = 0; n < 16; n++) src[1].push_back(8'($urandom));
      for (int n = 0; n < 12; n++) src[0].push_back(8'($urandom));
      for (int g = 0; g < 3000 &&
           (src[0].size() || src[1].size() || busy[0] || busy[1] || rx_act); g++) step();
      rnd_en = 1'b0;
      chk("stream_drained", src[0].size() + src[1].size() + int'(busy[0]) + int'(busy[1]), 0);
      chk("rx_count", rxq.size(), 16);
      for (int n = 0; n < 16 && n < rxq.size() && n < sent1.size(); n++)
         chk($sformatf("rx_byte%0d", n), rxq[n], sent1[n]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
